// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: opcodes, FSM state codes, flag bit positions.
package alu_pkg;

    localparam int W     = 8;
    localparam int NREGS = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH_B = 2'd1;
    localparam logic [1:0] S_EXEC    = 2'd2;
    localparam logic [1:0] S_WRITE   = 2'd3;

    localparam int FLAG_C = 3;
    localparam int FLAG_A = 2;
    localparam int FLAG_E = 1;
    localparam int FLAG_Z = 0;

    // Opcodes that chain the previous carry into the ALU.
    function automatic logic uses_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Bus between the sequencer (master) and the combinational 8-bit ALU (slave).
interface alu_ctrl_if;
    import alu_pkg::*;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_carry_in;
    logic [2:0]   alu_opcode;
    logic [W-1:0] alu_out;
    logic         alu_flag_a;
    logic         alu_flag_e;
    logic         alu_flag_z;
    logic         alu_flag_c;

    modport master (
        output alu_a, alu_b, alu_carry_in, alu_opcode,
        input  alu_out, alu_flag_a, alu_flag_e, alu_flag_z, alu_flag_c
    );

    modport slave (
        input  alu_a, alu_b, alu_carry_in, alu_opcode,
        output alu_out, alu_flag_a, alu_flag_e, alu_flag_z, alu_flag_c
    );

endinterface

// File: rtl/alu_regfile.sv
// 4x8 register file: one write port, two async operand reads and an async debug read.
module alu_regfile
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [1:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [1:0]   ra,
    input  logic [1:0]   rb,
    output logic [W-1:0] rd_a,
    output logic [W-1:0] rd_b,
    input  logic [1:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    logic [W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rd_a     = regs[ra];
    assign rd_b     = regs[rb];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle ALU instruction sequencer: IDLE -> FETCH_B -> EXEC -> WRITE, one instruction at a time.
module alu_ctrl
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instr_valid,
    input  logic [7:0]   instr,
    output logic         instr_ready,
    output logic         done,
    output logic         illegal,
    alu_ctrl_if.master   alu,
    output logic [3:0]   flags,
    input  logic         ext_we,
    input  logic [1:0]   ext_addr,
    input  logic [W-1:0] ext_wdata,
    input  logic [1:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    logic [1:0]   state;
    logic [7:0]   ir;
    logic [W-1:0] tmp;
    logic [W-1:0] acc;
    logic [W-1:0] a_hold;
    logic         ill_q;
    logic [3:0]   flags_q;

    logic [2:0]   op;
    logic [1:0]   ra;
    logic [1:0]   rb;
    logic [W-1:0] rd_a;
    logic [W-1:0] rd_b;
    logic         in_exec;
    logic         wr_result;
    logic         rf_we;
    logic [1:0]   rf_waddr;
    logic [W-1:0] rf_wdata;

    assign op = ir[6:4];
    assign ra = ir[3:2];
    assign rb = ir[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ir      <= '0;
            tmp     <= '0;
            acc     <= '0;
            a_hold  <= '0;
            ill_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        if (instr[7]) begin
                            ir    <= instr;
                            ill_q <= 1'b0;
                            state <= S_FETCH_B;
                        end else begin
                            ill_q <= 1'b1;
                            state <= S_WRITE;
                        end
                    end
                end
                S_FETCH_B: begin
                    tmp   <= rd_b;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    acc     <= alu.alu_out;
                    flags_q <= {alu.alu_flag_c, alu.alu_flag_a, alu.alu_flag_e, alu.alu_flag_z};
                    a_hold  <= rd_a;
                    state   <= S_WRITE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_exec     = (state == S_EXEC);
    assign instr_ready = (state == S_IDLE);
    assign done        = (state == S_WRITE);
    assign illegal     = (state == S_WRITE) && ill_q;
    assign flags       = flags_q;

    // Operand a is held in a register so it stays stable after EXEC even if reg[ra] is rewritten.
    assign alu.alu_opcode   = in_exec ? op : '0;
    assign alu.alu_a        = in_exec ? rd_a : a_hold;
    assign alu.alu_b        = tmp;
    assign alu.alu_carry_in = in_exec && uses_carry(op) && flags_q[FLAG_C];

    assign wr_result = (state == S_WRITE) && !ill_q && (op != OP_CMP);
    assign rf_we     = wr_result || ((state == S_IDLE) && ext_we);
    assign rf_waddr  = wr_result ? rb  : ext_addr;
    assign rf_wdata  = wr_result ? acc : ext_wdata;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .ra       (ra),
        .rb       (rb),
        .rd_a     (rd_a),
        .rd_b     (rd_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural combinational ALU on the slave side.
module tb_alu_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       done;
    logic       illegal;
    logic [3:0] flags;
    logic       ext_we;
    logic [1:0] ext_addr;
    logic [7:0] ext_wdata;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .done        (done),
        .illegal     (illegal),
        .alu         (bus.master),
        .flags       (flags),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    logic [8:0] sum;
    always_comb begin
        sum            = '0;
        bus.alu_out    = '0;
        bus.alu_flag_c = 1'b0;
        case (bus.alu_opcode)
            OP_ADD: begin
                sum            = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_carry_in};
                bus.alu_out    = sum[7:0];
                bus.alu_flag_c = sum[8];
            end
            OP_SHR: begin
                bus.alu_out    = {bus.alu_carry_in, bus.alu_b[7:1]};
                bus.alu_flag_c = bus.alu_b[0];
            end
            OP_SHL: begin
                bus.alu_out    = {bus.alu_b[6:0], bus.alu_carry_in};
                bus.alu_flag_c = bus.alu_b[7];
            end
            OP_NOT:  bus.alu_out = ~bus.alu_b;
            OP_AND:  bus.alu_out = bus.alu_a & bus.alu_b;
            OP_OR:   bus.alu_out = bus.alu_a | bus.alu_b;
            OP_XOR:  bus.alu_out = bus.alu_a ^ bus.alu_b;
            default: bus.alu_out = bus.alu_a - bus.alu_b;
        endcase
        bus.alu_flag_a = bus.alu_a > bus.alu_b;
        bus.alu_flag_e = bus.alu_a == bus.alu_b;
        bus.alu_flag_z = bus.alu_out == 8'd0;
    end

    task automatic ext_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ext_we = 1'b1; ext_addr = a; ext_wdata = d;
        @(posedge clk);
        #1 ext_we = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1 d = dbg_data;
    endtask

    // Offers one instruction, then observes six cycles (k=0 is the cycle after the accept edge).
    task automatic issue(input logic [7:0] ins, output int done_at, output int done_cnt,
                         output logic ill_at_done, output logic cin_exec,
                         output logic [2:0] op_exec, output int cin_cnt, output logic rdy_k1);
        done_at = -1; done_cnt = 0; ill_at_done = 1'b0; cin_exec = 1'b0;
        op_exec = '0; cin_cnt = 0; rdy_k1 = 1'b0;
        @(negedge clk);
        instr = ins; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) begin
                if (done_at < 0) begin
                    done_at = k;
                    ill_at_done = illegal;
                end
                done_cnt++;
            end
            if (k == 1) begin
                cin_exec = bus.alu_carry_in;
                op_exec  = bus.alu_opcode;
                rdy_k1   = instr_ready;
            end
            if (bus.alu_carry_in) cin_cnt++;
        end
    endtask

    int         d_at, d_cnt, c_cnt;
    logic       ill, cin, rdy;
    logic [2:0] opx;
    logic [7:0] rv;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
        checks++; if (bus.alu_opcode !== 3'b000) begin errors++; $display("FAIL reset_opcode: got %b expected 000", bus.alu_opcode); end
        checks++; if (bus.alu_a !== 8'h00) begin errors++; $display("FAIL reset_alu_a: got %h expected 00", bus.alu_a); end
        checks++; if (bus.alu_b !== 8'h00) begin errors++; $display("FAIL reset_alu_b: got %h expected 00", bus.alu_b); end
        checks++; if (bus.alu_carry_in !== 1'b0) begin errors++; $display("FAIL reset_cin: got %b expected 0", bus.alu_carry_in); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
        for (int r = 0; r < 4; r++) begin
            read_reg(r[1:0], rv);
            checks++; if (rv !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h expected 00", r, rv); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        ext_write(2'd0, 8'h05);
        ext_write(2'd1, 8'h03);
        issue(8'h81, d_at, d_cnt, ill, cin, opx, c_cnt, rdy);
        checks++; if (d_at !== 2) begin errors++; $display("FAIL add_latency: done at k=%0d expected k=2", d_at); end
        checks++; if (d_cnt !== 1) begin errors++; $display("FAIL add_done_count: got %0d expected 1", d_cnt); end
        checks++; if (ill !== 1'b0) begin errors++; $display("FAIL add_illegal: got %b expected 0", ill); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL add_busy_ready: got %b expected 0", rdy); end
        read_reg(2'd1, rv);
        checks++; if (rv !== 8'h08) begin errors++; $display("FAIL add_r1: got %h expected 08", rv); end
        read_reg(2'd0, rv);
        checks++; if (rv !== 8'h05) begin errors++; $display("FAIL add_r0: got %h expected 05", rv); end
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL add_flags: got %b expected 0100", flags); end
    endtask

    task automatic test_carry();
        ext_write(2'd0, 8'hFF);
        ext_write(2'd1, 8'h01);
        issue(8'h81, d_at, d_cnt, ill, cin, opx, c_cnt, rdy);
        read_reg(2'd1, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL carry_r1: got %h expected 00", rv); end
        checks++; if (flags !== 4'b1101) begin errors++; $display("FAIL carry_flags: got %b expected 1101", flags); end
        ext_write(2'd2, 8'h00);
        ext_write(2'd3, 8'h00);
        issue(8'h8B, d_at, d_cnt, ill, cin, opx, c_cnt, rdy);
        checks++; if (cin !== 1'b1) begin errors++; $display("FAIL carry_cin_exec: got %b expected 1", cin); end
        read_reg(2'd3, rv);
        checks++; if (rv !== 8'h01) begin errors++; $display("FAIL carry_r3: got %h expected 01", rv); end
        checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL carry_flags2: got %b expected 0010", flags); end
    endtask

    task automatic test_compare();
        ext_write(2'd0, 8'h22);
        ext_write(2'd1, 8'h22);
        issue(8'hF1, d_at, d_cnt, ill, cin, opx, c_cnt, rdy);
        checks++; if (opx !== 3'b111) begin errors++; $display("FAIL cmp_opcode: got %b expected 111", opx); end
        read_reg(2'd1, rv);
        checks++; if (rv !== 8'h22) begin errors++; $display("FAIL cmp_r1: got %h expected 22", rv); end
        checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL cmp_flags: got %b expected 0011", flags); end
        checks++; if (d_cnt !== 1) begin errors++; $display("FAIL cmp_done_count: got %0d expected 1", d_cnt); end
    endtask

    task automatic test_carry_gating();
        ext_write(2'd0, 8'hFF);
        ext_write(2'd1, 8'h01);
        issue(8'h81, d_at, d_cnt, ill, cin, opx, c_cnt, rdy);
        checks++; if (flags[FLAG_C] !== 1'b1) begin errors++; $display("FAIL gate_setup_c: got %b expected 1", flags[FLAG_C]); end
        issue(8'hC1, d_at, d_cnt, ill, cin, opx, c_cnt, rdy);
        checks++; if (c_cnt !== 0) begin errors++; $display("FAIL gate_cin: carry_in high %0d cycles expected 0", c_cnt); end
        checks++; if (opx !== 3'b100) begin errors++; $display("FAIL gate_opcode: got %b expected 100", opx); end
        read_reg(2'd1, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL gate_r1: got %h expected 00", rv); end
        checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL gate_flags: got %b expected 0101", flags); end
    endtask

    task automatic test_illegal();
        issue(8'h41, d_at, d_cnt, ill, cin, opx, c_cnt, rdy);
        checks++; if (d_at !== 0) begin errors++; $display("FAIL ill_latency: done at k=%0d expected k=0", d_at); end
        checks++; if (ill !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b expected 1", ill); end
        checks++; if (d_cnt !== 1) begin errors++; $display("FAIL ill_done_count: got %0d expected 1", d_cnt); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ill_ready: got %b expected 1", rdy); end
        checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL ill_flags: got %b expected 0101", flags); end
        read_reg(2'd0, rv);
        checks++; if (rv !== 8'hFF) begin errors++; $display("FAIL ill_r0: got %h expected FF", rv); end
        read_reg(2'd1, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL ill_r1: got %h expected 00", rv); end
        read_reg(2'd3, rv);
        checks++; if (rv !== 8'h01) begin errors++; $display("FAIL ill_r3: got %h expected 01", rv); end
    endtask

    task automatic test_same_cycle_write();
        ext_write(2'd0, 8'h05);
        @(negedge clk);
        instr = 8'h81; instr_valid = 1'b1;
        ext_we = 1'b1; ext_addr = 2'd1; ext_wdata = 8'h10;
        @(posedge clk);
        #1 instr_valid = 1'b0; ext_we = 1'b0;
        repeat (5) @(negedge clk);
        read_reg(2'd1, rv);
        checks++; if (rv !== 8'h15) begin errors++; $display("FAIL same_cycle_r1: got %h expected 15", rv); end
    endtask

    task automatic test_busy_ext_write();
        ext_write(2'd0, 8'h05);
        ext_write(2'd1, 8'h03);
        @(negedge clk);
        instr = 8'h81; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        ext_we = 1'b1; ext_addr = 2'd0; ext_wdata = 8'h77;
        @(posedge clk);
        #1 ext_we = 1'b0;
        repeat (4) @(negedge clk);
        read_reg(2'd0, rv);
        checks++; if (rv !== 8'h05) begin errors++; $display("FAIL busy_r0: got %h expected 05", rv); end
        read_reg(2'd1, rv);
        checks++; if (rv !== 8'h08) begin errors++; $display("FAIL busy_r1: got %h expected 08", rv); end
    endtask

    task automatic test_reset_mid();
        int dn;
        ext_write(2'd0, 8'h05);
        ext_write(2'd1, 8'h03);
        @(negedge clk);
        instr = 8'h81; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        dn = 0;
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", instr_ready); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b expected 0000", flags); end
        for (int k = 0; k < 4; k++) begin
            if (done) dn++;
            @(negedge clk);
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL rstmid_done: done seen %0d cycles expected 0", dn); end
        for (int r = 0; r < 4; r++) begin
            read_reg(r[1:0], rv);
            checks++; if (rv !== 8'h00) begin errors++; $display("FAIL rstmid_reg%0d: got %h expected 00", r, rv); end
        end
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; dbg_addr = '0;
        test_reset();
        test_add();
        test_carry();
        test_compare();
        test_carry_gating();
        test_illegal();
        test_same_cycle_write();
        test_busy_ext_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
